mem_arbiter_ctrl: RTL and testbench

Parametrised successor to the two-port instruction/data memory front end in the RISC-V Tomasulo core.
- Arbitrates NUM_CH request channels (fetch, LSB, future prefetch) onto the single byte-wide memory bus, round-robin.
- Serialises 1/2/4-byte reads and writes, and stalls I/O writes on io_buffer_full.
- Aborts flushable reads on ROB clear.
- Sits between fetch/LSB and the top-level mem_* pins.

---
 rtl/mem_arbiter_ctrl_pkg.sv | 38 +++
 rtl/mem_arbiter_ctrl_rr_arbiter.sv | 40 ++++
 rtl/mem_arbiter_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_ctrl_pkg
// Shared constants for the byte-wide memory front end:
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 3 behaves as word)
//   - sequencing FSM state encoding
//   - IO_HI: value of addr[17:16] that marks the memory-mapped I/O window
//   - helpers for the last byte index of a transfer and index vector width
// -----------------------------------------------------------------------------
package mem_arbiter_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] IO_HI = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RTAIL = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Index of the final byte of a transfer (n-1); size 3 is treated as a word.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Width of a channel index; at least one bit so a single channel still works.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Starting from the channel after
// i_last (cyclically), the first requesting channel wins.
//   i_req    [N-1:0]  request vector
//   i_last   [IW-1:0] index of the most recently served channel
//   o_grant  [N-1:0]  one-hot grant (all zero when nothing requests)
//   o_idx    [IW-1:0] binary index of the granted channel
// -----------------------------------------------------------------------------
module rr_arbiter
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;

  // Walk the distances from farthest to nearest so the channel closest after
  // i_last is written last and therefore wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = N; i >= 1; i--) begin
      w_cand = IW'((int'(i_last) + i) % N);
      if (i_req[w_cand]) begin
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// mem_arbiter_ctrl
// Round-robin front end that serialises 1/2/4-byte reads and writes from
// NUM_CH requesters onto a single byte-wide memory bus.
//   clk, rst        clock, synchronous active-high reset
//   rdy             global ready; low freezes the controller
//   clear           ROB flush; aborts in-flight reads on flushable channels
//   req_valid/wr/size/addr/wdata   per-channel request, held until resp_ready
//   resp_ready      one-cycle completion pulse to the granted channel
//   resp_data       zero-extended read data, valid with resp_ready
//   mem_din/mem_dout/mem_a/mem_wr  byte-wide memory bus
//   io_buffer_full  stalls writes to the I/O window (addr[17:16] == 2'b11)
// Read data for the byte presented in cycle t arrives on mem_din at the end
// of cycle t+1, so reads finish with one extra capture cycle (RTAIL).
// -----------------------------------------------------------------------------
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int                NUM_CH     = 2,
  parameter int                ADDR_W     = 32,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [2*NUM_CH-1:0]      req_size,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  output logic [NUM_CH-1:0]        resp_ready,
  output logic [31:0]              resp_data,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [31:0]              mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);

  localparam int IW = idx_w(NUM_CH);

  // Control state
  state_e          r_state;
  state_e          w_next;
  logic [IW-1:0]   r_last_grant;
  logic            r_cap_vld;
  logic [31:0]     r_resp_data;

  // Latched transaction
  logic [IW-1:0]   r_gidx;
  logic            r_wr;
  logic [1:0]      r_lastk;
  logic [1:0]      r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rbuf;
  logic [1:0]      r_cap_idx;

  // Arbitration and request selection
  logic [NUM_CH-1:0] w_grant;
  logic [IW-1:0]     w_gidx;
  logic              w_any;
  logic              w_sel_wr;
  logic [1:0]        w_sel_size;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;

  // Sequencing helpers
  logic [ADDR_W-1:0] w_addr_k;
  logic              w_io;
  logic              w_stall;
  logic              w_abort;
  logic [31:0]       w_merged;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_rr (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  assign w_any       = |w_grant;
  assign w_sel_wr    = req_wr[w_gidx];
  assign w_sel_size  = req_size[2*int'(w_gidx) +: 2];
  assign w_sel_addr  = req_addr[ADDR_W*int'(w_gidx) +: ADDR_W];
  assign w_sel_wdata = req_wdata[32*int'(w_gidx) +: 32];

  // Byte address wraps modulo 2^ADDR_W.
  assign w_addr_k = r_addr + ADDR_W'(r_cnt);

  // I/O window is decided on the base address of the access.
  assign w_io = (((32'(r_addr)) >> 16) & 32'h3) == 32'(IO_HI);

  // Only I/O writes stall; the byte is held with mem_wr low.
  assign w_stall = (r_state == XFER) && r_wr && w_io && io_buffer_full;

  // Committed stores are never aborted.
  assign w_abort = clear && !r_wr && FLUSH_MASK[r_gidx] &&
                   ((r_state == XFER) || (r_state == RTAIL));

  // Final read word: fold in the byte arriving this cycle, if one is due.
  always_comb begin
    w_merged = r_rbuf;
    if (r_cap_vld) w_merged[8*r_cap_idx +: 8] = mem_din;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)      r_state <= IDLE;
    else if (rdy) r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_any && !clear) w_next = XFER;
      XFER: begin
        if (w_abort)                            w_next = IDLE;
        else if (!w_stall && r_cnt == r_lastk)  w_next = r_wr ? DONE : RTAIL;
      end
      RTAIL: w_next = w_abort ? IDLE : DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_a      = '0;
    mem_wr     = 1'b0;
    mem_dout   = '0;
    resp_ready = '0;
    if (r_state == XFER) begin
      mem_a    = 32'(w_addr_k);
      mem_wr   = r_wr && !w_stall;
      mem_dout = r_wdata[8*r_cnt +: 8];
    end
    if (r_state == DONE) resp_ready[r_gidx] = 1'b1;
  end

  assign resp_data = r_resp_data;

  // Control registers: round-robin pointer, capture flag, response word.
  // The capture flag tracks what was on the bus last cycle even while rdy is
  // low: the memory keeps answering the held address, so the pending byte
  // must still be taken or it would be lost when rdy returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= IW'(NUM_CH - 1);
      r_cap_vld    <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_cap_vld <= (r_state == XFER) && !r_wr;
      if (rdy) begin
        case (r_state)
          XFER:    if (w_abort) r_last_grant <= r_gidx;
          RTAIL: begin
            if (w_abort) r_last_grant <= r_gidx;
            else         r_resp_data  <= w_merged;
          end
          DONE:    r_last_grant <= r_gidx;
          default: ;
        endcase
      end
    end
  end

  // Transaction registers: latched request, byte counter, read assembly.
  always_ff @(posedge clk) begin
    if (r_cap_vld) r_rbuf[8*r_cap_idx +: 8] <= mem_din;
    r_cap_idx <= r_cnt;
    if (rdy) begin
      case (r_state)
        IDLE: begin
          if (w_any && !clear) begin
            r_gidx  <= w_gidx;
            r_wr    <= w_sel_wr;
            r_lastk <= last_byte_idx(w_sel_size);
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= '0;
            r_rbuf  <= '0;
          end
        end
        XFER: begin
          if (!w_abort && !w_stall && r_cnt != r_lastk) r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
module tb_mem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, io_buffer_full;
  logic [1:0]  req_valid, req_wr;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  resp_ready;
  logic [31:0] resp_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_arbiter_ctrl #(.NUM_CH(2), .ADDR_W(32), .FLUSH_MASK(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Memory model: registered read (data for address of cycle t on mem_din in t+1)
  bit [7:0] mem   [0:1023];
  bit       mem_w [0:1023];

  function automatic logic [7:0] init_byte(input logic [9:0] a);
    case (a)
      10'h100: return 8'h11;
      10'h101: return 8'h22;
      10'h102: return 8'h33;
      10'h103: return 8'h44;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_din <= mem_w[mem_a[9:0]] ? mem[mem_a[9:0]] : init_byte(mem_a[9:0]);
    if (mem_wr && !rst) begin
      mem[mem_a[9:0]]   <= mem_dout;
      mem_w[mem_a[9:0]] <= 1'b1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard
  typedef struct packed { logic [1:0] oh; logic rd; logic [31:0] data; } resp_t;
  typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
  resp_t exp_resp[$];
  wr_t   exp_wr[$];
  resp_t mon_r;
  wr_t   mon_w;

  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (resp_ready != 2'b00) begin
        if (exp_resp.size() == 0) chk("resp_unexpected", 64'(resp_ready), 64'(0));
        else begin
          mon_r = exp_resp.pop_front();
          chk("resp_ch", 64'(resp_ready), 64'(mon_r.oh));
          if (mon_r.rd) chk("resp_data", 64'(resp_data), 64'(mon_r.data));
        end
      end
      if (mem_wr) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 64'(mem_a), 64'hFFFF_FFFF_FFFF);
        else begin
          mon_w = exp_wr.pop_front();
          chk("wr_byte", {24'(0), mem_a, mem_dout}, {24'(0), mon_w.a, mon_w.d});
        end
      end
    end
  end

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int ch, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    req_wr[ch]            = wr;
    req_size[2*ch +: 2]   = sz;
    req_addr[32*ch +: 32] = a;
    req_wdata[32*ch +: 32] = wd;
    req_valid[ch]         = 1'b1;
  endtask

  task automatic push_resp(input logic [1:0] oh, input logic rd, input logic [31:0] d);
    resp_t r;
    r.oh = oh; r.rd = rd; r.data = d;
    exp_resp.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic run_req(input int ch, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_data, input string tag);
    int n, lat;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (wr) for (int k = 0; k < n; k++) push_wr(a + 32'(k), wd[8*k +: 8]);
    push_resp(2'(1 << ch), !wr, exp_data);
    set_req(ch, wr, sz, a, wd);
    lat = 0;
    do begin go(); lat++; end while (!resp_ready[ch] && lat < 40);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    req_valid[ch] = 1'b0;
    go();
  endtask

  int model_last;
  int e, w;

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    req_valid = '0; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    model_last = 1;
    go(); go(); go();
    chk("rst_mem_a",  64'(mem_a), 64'(0));
    chk("rst_mem_wr", 64'(mem_wr), 64'(0));
    chk("rst_dout",   64'(mem_dout), 64'(0));
    chk("rst_rr",     64'(resp_ready), 64'(0));
    chk("rst_rdata",  64'(resp_data), 64'(0));
    rst = 1'b0;
    go();

    // 1: word read, exact cycle timing
    push_resp(2'b01, 1'b1, 32'h4433_2211);
    set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      go();
      if (c <= 4) chk("t1_addr", 64'(mem_a), 64'(32'h100 + 32'(c - 1)));
      if (c == 5) chk("t1_tail_a", 64'(mem_a), 64'(0));
      chk("t1_rr", 64'(resp_ready), (c == 6) ? 64'(1) : 64'(0));
    end
    req_valid[0] = 1'b0;
    go();
    model_last = 0;

    // 2: round robin with both channels requesting byte reads
    set_req(0, 1'b0, 2'd0, 32'h100, 32'h0);
    set_req(1, 1'b0, 2'd0, 32'h101, 32'h0);
    for (int it = 0; it < 4; it++) begin
      e = 1 - model_last;
      push_resp(2'(1 << e), 1'b1, (e == 0) ? 32'h11 : 32'h22);
      w = 0;
      do begin go(); w++; end while (resp_ready == 2'b00 && w < 10);
      chk("t2_grant", 64'(resp_ready), 64'(1 << e));
      chk("t2_wait", 64'(w), (it == 0) ? 64'(3) : 64'(4));
      model_last = e;
    end
    req_valid = '0;
    go();

    // 3: I/O write stalled by io_buffer_full for 3 cycles
    push_wr(32'h30000, 8'h41);
    push_resp(2'b10, 1'b0, 32'h0);
    set_req(1, 1'b1, 2'd0, 32'h30000, 32'h41);
    io_buffer_full = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      go();
      chk("t3_stall_wr", 64'(mem_wr), 64'(0));
      chk("t3_stall_a", 64'(mem_a), 64'(32'h30000));
    end
    go();
    io_buffer_full = 1'b0;
    #1;
    chk("t3_wr", 64'(mem_wr), 64'(1));
    chk("t3_dout", 64'(mem_dout), 64'(8'h41));
    go();
    chk("t3_rr", 64'(resp_ready), 64'(2'b10));
    req_valid[1] = 1'b0;
    go();

    // 4: clear aborts a flushable read; ch1 then served normally
    set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
    go();
    chk("t4_a1", 64'(mem_a), 64'(32'h100));
    go();
    clear = 1'b1;
    #1;
    chk("t4_a2", 64'(mem_a), 64'(32'h101));
    go();
    clear = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    chk("t4_idle_a", 64'(mem_a), 64'(0));
    chk("t4_idle_wr", 64'(mem_wr), 64'(0));
    chk("t4_no_rr", 64'(resp_ready), 64'(0));
    run_req(1, 1'b0, 2'd0, 32'h101, 32'h0, 3, 32'h22, "t4_ch1");

    // 5: half store is not aborted by clear
    push_wr(32'h200, 8'hEF);
    push_wr(32'h201, 8'hBE);
    push_resp(2'b10, 1'b0, 32'h0);
    set_req(1, 1'b1, 2'd1, 32'h200, 32'h0000_BEEF);
    go();
    clear = 1'b1;
    #1;
    chk("t5_wr1", 64'(mem_wr), 64'(1));
    chk("t5_a1", 64'(mem_a), 64'(32'h200));
    chk("t5_d1", 64'(mem_dout), 64'(8'hEF));
    go();
    clear = 1'b0;
    #1;
    chk("t5_a2", 64'(mem_a), 64'(32'h201));
    chk("t5_d2", 64'(mem_dout), 64'(8'hBE));
    go();
    chk("t5_rr", 64'(resp_ready), 64'(2'b10));
    req_valid[1] = 1'b0;
    go();

    // Read-back (little-endian, zero-extended) and size 3 as word
    run_req(0, 1'b0, 2'd1, 32'h200, 32'h0, 4, 32'h0000_BEEF, "t5_rb");
    run_req(1, 1'b1, 2'd3, 32'h300, 32'hA1B2_C3D4, 5, 32'h0, "sz3_wr");
    run_req(0, 1'b0, 2'd2, 32'h300, 32'h0, 6, 32'hA1B2_C3D4, "sz3_rd");

    // 6: rdy low for 4 cycles mid-read
    push_resp(2'b01, 1'b1, 32'h4433_2211);
    set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
    go();
    chk("t6_a1", 64'(mem_a), 64'(32'h100));
    go();
    chk("t6_a2", 64'(mem_a), 64'(32'h101));
    rdy = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      go();
      chk("t6_frozen_a", 64'(mem_a), 64'(32'h101));
      chk("t6_frozen_rr", 64'(resp_ready), 64'(0));
    end
    rdy = 1'b1;
    go();
    chk("t6_a3", 64'(mem_a), 64'(32'h102));
    go();
    chk("t6_a4", 64'(mem_a), 64'(32'h103));
    go();
    chk("t6_tail", 64'(mem_a), 64'(0));
    go();
    chk("t6_rr", 64'(resp_ready), 64'(2'b01));
    req_valid[0] = 1'b0;
    go();

    // 7: reset mid-write discards the transfer
    push_wr(32'h380, 8'h88);
    set_req(0, 1'b1, 2'd2, 32'h380, 32'h5566_7788);
    go();
    chk("t7_wr1", 64'(mem_wr), 64'(1));
    go();
    rst = 1'b1;
    go();
    rst = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    chk("t7_wr", 64'(mem_wr), 64'(0));
    chk("t7_a", 64'(mem_a), 64'(0));
    chk("t7_rdata", 64'(resp_data), 64'(0));
    for (int c = 0; c < 6; c++) go();

    // 8: after reset channel 0 wins first, then channel 1
    set_req(0, 1'b0, 2'd0, 32'h100, 32'h0);
    set_req(1, 1'b0, 2'd0, 32'h101, 32'h0);
    push_resp(2'b01, 1'b1, 32'h11);
    w = 0;
    do begin go(); w++; end while (resp_ready == 2'b00 && w < 10);
    chk("t8_first", 64'(resp_ready), 64'(2'b01));
    chk("t8_first_lat", 64'(w), 64'(3));
    req_valid[0] = 1'b0;
    push_resp(2'b10, 1'b1, 32'h22);
    w = 0;
    do begin go(); w++; end while (resp_ready == 2'b00 && w < 10);
    chk("t8_second", 64'(resp_ready), 64'(2'b10));
    chk("t8_second_lat", 64'(w), 64'(4));
    req_valid = '0;
    go(); go();

    chk("sb_resp_empty", 64'(exp_resp.size()), 64'(0));
    chk("sb_wr_empty", 64'(exp_wr.size()), 64'(0));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
